// File: rtl/pci_master_initiator.sv
// PCI bus initiator: accepts one burst request from local logic, runs the
// address phase, then 1..MAX_BURST data phases under IRDY/TRDY, and reports
// completion or master abort. FRAME, IRDY, TRDY and DEVSEL are active-low.
module pci_master_initiator #(
  parameter int MAX_BURST      = 16,
  parameter int LEN_W          = 5,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [3:0]       req_cmd,
  input  logic [3:0]       req_be,
  input  logic [LEN_W-1:0] req_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             abort,
  output logic [31:0]      AD_OUT,
  output logic             AD_OE,
  input  logic [31:0]      AD_IN,
  output logic [3:0]       C_BE_OUT,
  output logic             FRAME,
  output logic             IRDY,
  input  logic             TRDY,
  input  logic             DEVSEL
);

  localparam int CNT_W = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    ABORT
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [31:0]      addr_q;
  logic [3:0]       cmd_q;
  logic [3:0]       be_q;
  logic             is_write;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      buf_data;
  logic             buf_full;
  logic             claimed;
  logic [CNT_W-1:0] dev_cnt;

  logic             phase_done;
  logic             last_phase;
  logic             timeout;
  logic             irdy_int;
  logic [LEN_W-1:0] len_eff;

  // Zero-length requests run one phase; oversized ones are clamped to a full burst
  always_comb begin
    len_eff = req_len;
    if (req_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (req_len > LEN_W'(MAX_BURST)) begin
      len_eff = LEN_W'(MAX_BURST);
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and bus drive; FRAME is released only alongside IRDY=0 on the final phase
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    FRAME      = 1'b1;
    irdy_int   = 1'b1;
    AD_OE      = 1'b0;
    AD_OUT     = '0;
    C_BE_OUT   = 4'hF;
    phase_done = 1'b0;
    last_phase = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = ADDR;
        end
      end
      ADDR: begin
        FRAME      = 1'b0;
        AD_OE      = 1'b1;
        AD_OUT     = addr_q;
        C_BE_OUT   = cmd_q;
        next_state = DATA;
      end
      DATA: begin
        C_BE_OUT = be_q;
        if (is_write) begin
          AD_OE    = 1'b1;
          AD_OUT   = buf_data;
          irdy_int = ~buf_full;
          wr_ready = ~buf_full;
        end else begin
          irdy_int = 1'b0;
        end
        last_phase = (remaining == LEN_W'(1));
        FRAME      = last_phase ? ~irdy_int : 1'b0;
        phase_done = ~irdy_int & ~TRDY;
        timeout    = ~claimed & DEVSEL & (dev_cnt == CNT_W'(DEVSEL_TIMEOUT - 1));
        if (timeout) begin
          next_state = ABORT;
        end else if (phase_done && last_phase) begin
          next_state = IDLE;
        end
      end
      ABORT: begin
        FRAME      = 1'b1;
        irdy_int   = 1'b0;
        C_BE_OUT   = be_q;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    IRDY = irdy_int;
  end

  // Request latch, write buffer, DEVSEL watchdog, read capture and completion pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q    <= '0;
      cmd_q     <= '0;
      be_q      <= 4'hF;
      is_write  <= 1'b0;
      remaining <= '0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      claimed   <= 1'b0;
      dev_cnt   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            cmd_q     <= req_cmd;
            be_q      <= req_be;
            is_write  <= req_cmd[0];
            remaining <= len_eff;
            buf_full  <= 1'b0;
          end
        end
        ADDR: begin
          dev_cnt <= '0;
          claimed <= 1'b0;
        end
        DATA: begin
          if (!DEVSEL) begin
            claimed <= 1'b1;
          end else if (!claimed) begin
            dev_cnt <= dev_cnt + CNT_W'(1);
          end
          if (wr_valid && wr_ready) begin
            buf_data <= wr_data;
            buf_full <= 1'b1;
          end
          if (phase_done) begin
            remaining <= remaining - LEN_W'(1);
            buf_full  <= 1'b0;
            if (!is_write) begin
              rd_data  <= AD_IN;
              rd_valid <= 1'b1;
            end
            if (last_phase && !timeout) begin
              done <= 1'b1;
            end
          end
        end
        ABORT: begin
          done     <= 1'b1;
          abort    <= 1'b1;
          buf_full <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
